fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
// - Instruction prefetch FIFO between the program counter / instruction memory (fetch) and decode.
// - Holds {PC, instruction} pairs so fetch keeps running while decode stalls; a flush discards all queued work.
// - Backpressure to fetch via FetchReady: the PC holds its value while FetchReady=0.
// PARAMETERS
// - DEPTH  4      entries; power of two, >=2
// - AW     $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
// - Clk         in   1   clock, all state on posedge
// - Rst         in   1   asynchronous, active-high reset
// - Flush       in   1   discard all entries (branch/jump taken)
// - FetchValid  in   1   fetch presents a valid pair this cycle
// - FetchPC     in   32  PC of the fetched instruction
// - FetchInstr  in   32  fetched instruction word
// - FetchReady  out  1   buffer accepts a push this cycle
// - IDValid     out  1   head entry valid for decode
// - IDPC        out  32  PC of head entry
// - IDInstr     out  32  instruction of head entry
// - IDReady     in   1   decode consumes head this cycle
// - Count       out  AW+1  current occupancy, 0..DEPTH
// BEHAVIOUR
// - Clock and reset: single clock Clk; Rst asynchronous, active-high. Rst=1 forces wr_ptr=rd_ptr=0, Count=0, all storage to 0.
// - Reset values: IDValid=0, IDPC=0, IDInstr=32'h0000_0000 (NOP), FetchReady=1, Count=0.
// - Push: FetchValid & FetchReady -> entry written at wr_ptr; wr_ptr+1 mod DEPTH.
// - Pop: IDValid & IDReady -> rd_ptr+1 mod DEPTH.
// - FetchReady = (Count != DEPTH); combinational from current state only. Pop does not free a slot for a push in the same cycle.
// - IDValid = (Count != 0). IDPC/IDInstr are driven from the head storage register (first-word fall-through, no extra register).
// - Empty: IDPC=0, IDInstr=NOP regardless of stale storage.
// - Latency: a pair pushed on edge N is visible on IDValid/IDPC/IDInstr after edge N; no same-cycle bypass.
// - Count update: push only +1; pop only -1; push & pop same cycle: unchanged; never exceeds DEPTH, never underflows.
// - Pointer wrap: pointers are AW bits and wrap naturally; Count disambiguates full from empty.
// - Flush is synchronous and has highest priority. On a Flush edge:
//   - wr_ptr=rd_ptr=0 and Count=0;
//   - any push or pop in that cycle is discarded and not counted;
//   - IDValid=0 from the next cycle.
// - Storage contents are not cleared on flush; the empty-output rule masks them.
// - Rst asserted mid-operation: immediate return to reset values, no clock required. Deassertion is synchronous to Clk in the system.
// - Ordering: strict FIFO; PC/instruction pairing is never split.
// STRUCTURE
// - Shared package (cpu_pkg):
//   - localparam NOP_INSTR = 32'h0000_0000;
//   - typedef struct packed {logic [31:0] pc; logic [31:0] instr;} fetch_entry_t.
// - One sub-module: fetch_buffer_mem, a DEPTH x 64 register array.
//   - Ports: write port (we, waddr, wdata) and async read port (raddr, rdata).
//   - Reset on Rst.
// - Pointer/count control lives in fetch_buffer itself.
// TESTING
// - Reset then idle: Count=0, IDValid=0, IDInstr=0, FetchReady=1; async Rst mid-cycle clears immediately.
// - Push PC 0x00,0x04,0x08,0x0C with IDReady=0 (DEPTH=4): Count=4, FetchReady=0. A 5th push at PC 0x10 is not accepted; Count stays 4.
// - Drain from full with IDReady=1: IDPC sequence 0x00,0x04,0x08,0x0C on consecutive cycles, then IDValid=0 and IDInstr=NOP.
// - Simultaneous push/pop at Count=2 for 10 cycles: Count stays 2, pointers wrap past DEPTH, output order preserved.
// - Flush at Count=3 with FetchValid=1 and IDReady=1 in the same cycle: next cycle Count=0 and IDValid=0. Neither the push nor the pop took effect; the next push is seen after one edge.
// - Random push/pop/flush 10k cycles vs a queue model: IDPC/IDInstr/Count match every cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch/decode handoff entry and the NOP encoding.
package cpu_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_mem.sv
// DEPTH x 64 register array holding {PC, instruction} pairs.
// One synchronous write port and one asynchronous read port.
module fetch_buffer_mem
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fetch_entry_t  wdata,
   input  logic [AW-1:0] raddr,
   output fetch_entry_t  rdata
);

   fetch_entry_t mem_q [DEPTH];
   fetch_entry_t mem_d [DEPTH];

   // Next-state of the array: copy current contents, overwrite the written slot.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Storage registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         // NOTE: this small register array is reset so the fall-through read path
         // never exposes X; a large RAM macro would normally be left unreset.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch FIFO between fetch and decode. Holds {PC, instr} pairs,
// first-word fall-through on the decode side, flush empties it in one edge.
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Flush,
   input  logic          FetchValid,
   input  logic [31:0]   FetchPC,
   input  logic [31:0]   FetchInstr,
   output logic          FetchReady,
   output logic          IDValid,
   output logic [31:0]   IDPC,
   output logic [31:0]   IDInstr,
   input  logic          IDReady,
   output logic [AW:0]   Count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;

   logic          push;
   logic          pop;
   logic          mem_we;
   fetch_entry_t  wr_entry;
   fetch_entry_t  head_entry;

   // Handshake status comes from registered occupancy only, so a pop never
   // frees a slot for a push in the same cycle.
   assign FetchReady = (count_q != FULL_COUNT);
   assign IDValid    = (count_q != '0);
   assign push       = FetchValid && FetchReady;
   assign pop        = IDValid && IDReady;

   // Pointer and occupancy next-state; flush overrides any push/pop.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a value unassigned and infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_we   = 1'b0;
      if (Flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            mem_we   = 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop
         // samples pre-edge values regardless of statement order.
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_entry = '{pc: FetchPC, instr: FetchInstr};

   fetch_buffer_mem #(.DEPTH(DEPTH)) u_mem (
      .Clk   (Clk),
      .Rst   (Rst),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (head_entry)
   );

   // Stale storage is masked while empty so decode sees PC 0 and a NOP.
   assign IDPC    = IDValid ? head_entry.pc    : 32'h0;
   assign IDInstr = IDValid ? head_entry.instr : NOP_INSTR;
   assign Count   = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed corner cases plus random
// push/pop/flush traffic against a queue-based reference model.
module tb_fetch_buffer;
   import cpu_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = $clog2(DEPTH);

   logic          Clk        = 1'b0;
   logic          Rst        = 1'b1;
   logic          Flush      = 1'b0;
   logic          FetchValid = 1'b0;
   logic [31:0]   FetchPC    = '0;
   logic [31:0]   FetchInstr = '0;
   logic          FetchReady;
   logic          IDValid;
   logic [31:0]   IDPC;
   logic [31:0]   IDInstr;
   logic          IDReady    = 1'b0;
   logic [AW:0]   Count;

   int total = 0;
   int bad   = 0;

   fetch_entry_t exp_q [$];

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .Flush      (Flush),
      .FetchValid (FetchValid),
      .FetchPC    (FetchPC),
      .FetchInstr (FetchInstr),
      .FetchReady (FetchReady),
      .IDValid    (IDValid),
      .IDPC       (IDPC),
      .IDInstr    (IDInstr),
      .IDReady    (IDReady),
      .Count      (Count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue updated from the inputs seen at each edge.
   always @(posedge Clk or posedge Rst) begin
      int  n;
      bit  do_push;
      bit  do_pop;
      if (Rst || Flush) begin
         exp_q.delete();
      end else begin
         n       = exp_q.size();
         do_push = FetchValid && (n < DEPTH);
         do_pop  = IDReady && (n > 0);
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back('{pc: FetchPC, instr: FetchInstr});
      end
   end

   // Monitor: compare DUT outputs with the model on every falling edge.
   always @(negedge Clk) begin
      int n;
      if (!Rst) begin
         n = exp_q.size();
         check("sb_count", Count, n);
         check("sb_fetch_ready", FetchReady, n != DEPTH);
         check("sb_id_valid", IDValid, n != 0);
         if (n != 0) begin
            check("sb_id_pc", IDPC, exp_q[0].pc);
            check("sb_id_instr", IDInstr, exp_q[0].instr);
         end else begin
            check("sb_empty_pc", IDPC, 32'h0);
            check("sb_empty_instr", IDInstr, NOP_INSTR);
         end
      end
   end

   // One clock of stimulus; returns 1 time unit after the edge.
   task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl);
      FetchValid = fv;
      FetchPC    = pc;
      FetchInstr = ins;
      IDReady    = rdy;
      Flush      = fl;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // Reset and idle
      @(posedge Clk);
      @(posedge Clk);
      #1;
      check("rst_count", Count, 0);
      check("rst_id_valid", IDValid, 0);
      check("rst_id_instr", IDInstr, 32'h0);
      check("rst_fetch_ready", FetchReady, 1);
      Rst = 1'b0;
      cyc(0, 0, 0, 0, 0);
      check("idle_count", Count, 0);

      // Fill to full, then an extra push is refused
      for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0, 0);
      check("full_count", Count, 4);
      check("full_fetch_ready", FetchReady, 0);
      cyc(1, 32'h10, 32'hA000_0010, 0, 0);
      check("overfill_count", Count, 4);
      check("overfill_head_pc", IDPC, 32'h0);

      // Drain from full
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", IDPC, 32'(i * 4));
         check("drain_instr", IDInstr, 32'hA000_0000 + 32'(i));
         cyc(0, 0, 0, 1, 0);
      end
      check("drained_valid", IDValid, 0);
      check("drained_instr", IDInstr, 32'h0);

      // Steady push+pop at Count=2, pointers wrap
      cyc(1, 32'h100, 32'hB000_0000, 0, 0);
      cyc(1, 32'h104, 32'hB000_0001, 0, 0);
      for (int k = 0; k < 10; k++) begin
         check("steady_head_pc", IDPC, 32'h100 + 32'(k * 4));
         cyc(1, 32'h108 + 32'(k * 4), 32'hB000_0002 + 32'(k), 1, 0);
         check("steady_count", Count, 2);
      end
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);
      check("steady_drained", Count, 0);

      // Flush at Count=3 with push and pop requested in the same cycle
      for (int i = 0; i < 3; i++) cyc(1, 32'h200 + 32'(i * 4), 32'hC000_0000 + 32'(i), 0, 0);
      check("preflush_count", Count, 3);
      cyc(1, 32'h300, 32'hC000_0300, 1, 1);
      check("flush_count", Count, 0);
      check("flush_valid", IDValid, 0);
      cyc(1, 32'h400, 32'hDEAD_0400, 0, 0);
      check("postflush_count", Count, 1);
      check("postflush_valid", IDValid, 1);
      check("postflush_pc", IDPC, 32'h400);

      // Asynchronous reset in mid-cycle
      cyc(1, 32'h404, 32'hDEAD_0404, 0, 0);
      FetchValid = 1'b0;
      #2;
      Rst = 1'b1;
      #1;
      check("async_rst_count", Count, 0);
      check("async_rst_valid", IDValid, 0);
      check("async_rst_pc", IDPC, 32'h0);
      check("async_rst_ready", FetchReady, 1);
      @(posedge Clk);
      #1;
      Rst = 1'b0;

      // Random traffic checked by the monitor
      for (int c = 0; c < 10000; c++) begin
         cyc($urandom_range(0, 99) < 65, $urandom & 32'hFFFF_FFFC, $urandom,
             $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 3);
      end
      cyc(0, 0, 0, 0, 0);
      @(negedge Clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
